// File: rtl/aes_inv_last_round.sv
// AES-128 inverse cipher last round: InvSubBytes(InvShiftRows(IN_DATA)) ^ IN_KEY, LANES bytes per cycle.
// Optional build macro AES_INV_ZEROIZE_EN clears the data and key registers on the output handshake.
module aes_inv_last_round #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [127:0] IN_DATA,
    input  logic [127:0] IN_KEY,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] OUT_DATA,
    output logic         BUSY
);

    localparam int N     = 16 / LANES;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("aes_inv_last_round: LANES must be 1, 2, 4, 8 or 16");
    end

    // Element i of a block is byte i, i.e. bits [127-8i -: 8] of the flat vector.
    typedef logic [0:15][7:0] blk_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    blk_t             data_q;
    blk_t             data_d;
    blk_t             key_q;
    logic [3:0]       idx;

    function automatic blk_t inv_shift_rows(input blk_t s);
        blk_t r;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[row + 4 * c] = s[row + 4 * ((c - row + 4) % 4)];
            end
        end
        return r;
    endfunction

    // One group of LANES bytes is substituted and keyed in place per SUB cycle.
    always_comb begin
        data_d = data_q;
        idx    = '0;
        for (int l = 0; l < LANES; l++) begin
            idx         = 4'(int'(cnt_q) * LANES + l);
            data_d[idx] = INV_SBOX[data_q[idx]] ^ key_q[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            key_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (IN_VALID) begin
                        data_q  <= inv_shift_rows(IN_DATA);
                        key_q   <= IN_KEY;
                        cnt_q   <= '0;
                        state_q <= SUB;
                    end
                end
                SUB: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_q <= OUT;
                    end
                end
                OUT: begin
                    if (OUT_READY) begin
                        state_q <= IDLE;
`ifdef AES_INV_ZEROIZE_EN
                        data_q  <= '0;
                        key_q   <= '0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign BUSY      = (state_q == SUB);
    assign OUT_VALID = (state_q == OUT);
    assign OUT_DATA  = data_q;

endmodule
